// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache for the fetch stage.
// 4-word (16 B) lines, filled word 0..3 over a req/ack word bus.
// q is registered (one-cycle read latency); hit is combinational.
// Optional feature macro: ICACHE_INVALIDATE_EN adds the inval port,
// which clears every valid bit.
module instr_cache #(
  parameter int INDEX_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  output logic [31:0] q,
  output logic        hit,
  input  logic        hold,
  input  logic        clear,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_q
`ifdef ICACHE_INVALIDATE_EN
  ,
  input  logic        inval
`endif
);

  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = 32 - 4 - INDEX_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Address fields of the current fetch address
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_offset;
  logic               w_unused;

  assign w_index  = addr[4+INDEX_W-1:4];
  assign w_tag    = addr[31:4+INDEX_W];
  assign w_offset = addr[3:2];
  // Byte-within-word bits carry no meaning for word fetches
  assign w_unused = ^addr[1:0];

  // State
  logic [0:0]         r_state;
  logic [1:0]         r_k;
  logic [TAG_W-1:0]   r_fill_tag;
  logic [INDEX_W-1:0] r_fill_index;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [31:0]        r_data [LINES*4];
  logic [31:0]        r_q;

  logic w_hit;
  logic w_miss_start;
  logic w_fill_ack;
  logic w_fill_done;
  logic w_fill_kill;

  assign w_hit        = (r_state == ST_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss_start = (r_state == ST_IDLE) && !w_hit;
  // Acks outside FILL are ignored because bus_req is low there
  assign w_fill_ack   = (r_state == ST_FILL) && bus_ack;
  assign w_fill_done  = w_fill_ack && (r_k == 2'd3);

`ifdef ICACHE_INVALIDATE_EN
  logic r_inval_seen;

  // Remember an invalidate that lands while a fill is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inval_seen <= 1'b0;
    end else if (w_miss_start) begin
      r_inval_seen <= 1'b0;
    end else if ((r_state == ST_FILL) && inval) begin
      r_inval_seen <= 1'b1;
    end
  end

  // A line whose fill overlapped an invalidate must not come up valid
  assign w_fill_kill = r_inval_seen || inval;
`else
  assign w_fill_kill = 1'b0;
`endif

  // Fill FSM: latch the missing line on entry, count words on each ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_k          <= 2'd0;
      r_fill_tag   <= '0;
      r_fill_index <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_hit) begin
            r_state      <= ST_FILL;
            r_k          <= 2'd0;
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
          end
        end
        default: begin
          if (w_fill_ack) begin
            r_k <= r_k + 2'd1;
            if (r_k == 2'd3) begin
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Valid bits: drop on fill entry, set on fill completion, cleared by invalidate
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_miss_start) begin
        r_valid[w_index] <= 1'b0;
      end
      if (w_fill_done && !w_fill_kill) begin
        r_valid[r_fill_index] <= 1'b1;
      end
`ifdef ICACHE_INVALIDATE_EN
      if (inval) begin
        r_valid <= '0;
      end
`endif
    end
  end

  // Tag array: written once per completed fill, never reset
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[r_fill_index] <= r_fill_tag;
    end
  end

  // Data array write port: one word per bus ack
  always_ff @(posedge clk) begin
    if (w_fill_ack) begin
      r_data[{r_fill_index, r_k}] <= bus_q;
    end
  end

  // Registered read into DE: clear/reset bubble, hold stall, else hit data or NOP
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_q <= '0;
    end else if (!hold) begin
      r_q <= w_hit ? r_data[{w_index, w_offset}] : '0;
    end
  end

  assign q        = r_q;
  assign hit      = w_hit;
  assign bus_req  = (r_state == ST_FILL);
  assign bus_addr = (r_state == ST_FILL) ? {r_fill_tag, r_fill_index, r_k, 2'b00} : 32'd0;

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed test of instr_cache with a behavioural word-bus slave.
// Build with ICACHE_INVALIDATE_EN defined to also exercise the invalidate port.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] q;
  logic        hit;
  logic        hold;
  logic        clear;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_q;
  logic        inval;

  int n_checks = 0;
  int n_fail   = 0;
  int slave_delay = 0;
  int slave_cnt   = 0;
  logic [31:0] bus_log [$];

  always #5 clk = ~clk;

  instr_cache #(.INDEX_W(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .q        (q),
    .hit      (hit),
    .hold     (hold),
    .clear    (clear),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_ack  (bus_ack),
    .bus_q    (bus_q)
`ifdef ICACHE_INVALIDATE_EN
    ,
    .inval    (inval)
`endif
  );

  // Backing memory contents: the first line holds 0x11..0x14
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'h10) w = 32'h11 + {30'd0, a[3:2]};
    else            w = a ^ 32'hA5A5_0000;
    return w;
  endfunction

  // Bus slave: ack after slave_delay idle cycles, log each acked address
  always @(negedge clk) begin
    if (reset || !bus_req) begin
      bus_ack   = 1'b0;
      slave_cnt = 0;
    end else if (slave_cnt >= slave_delay) begin
      bus_ack   = 1'b1;
      bus_q     = mem_word(bus_addr);
      bus_log.push_back(bus_addr);
      slave_cnt = 0;
    end else begin
      bus_ack   = 1'b0;
      slave_cnt = slave_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_hit(input int budget, output int n);
    n = 0;
    while (hit !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Compare four logged bus addresses starting at log position start
  task automatic check_log(input string tag, input int start, input logic [31:0] base);
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      got = (start + i < bus_log.size()) ? bus_log[start+i] : 32'hDEAD_BEEF;
      check($sformatf("%s word%0d", tag, i), got, base + 32'(4 * i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; addr = 32'h0; hold = 1'b0; clear = 1'b0; inval = 1'b0;
    bus_ack = 1'b0; bus_q = 32'h0;
    tick(); tick();
    check("reset q", q, 32'h0);
    check("reset bus_req", {31'd0, bus_req}, 32'd0);
    check("reset bus_addr", bus_addr, 32'h0);

    // 1: cold miss on 0x0, zero-wait fill
    bus_log.delete();
    reset = 1'b0;
    #1;
    check("t1 miss", {31'd0, hit}, 32'd0);
    wait_hit(20, n);
    check("t1 miss-to-hit cycles", n, 32'd5);
    check("t1 hit", {31'd0, hit}, 32'd1);
    check("t1 log size", bus_log.size(), 32'd4);
    check_log("t1 bus_addr", 0, 32'h0);
    check("t1 q before", q, 32'h0);
    tick();
    check("t1 q", q, 32'h11);

    // 2: back-to-back hits on 0x4, 0x8
    addr = 32'h4; #1;
    check("t2 hit 0x4", {31'd0, hit}, 32'd1);
    check("t2 bus_req", {31'd0, bus_req}, 32'd0);
    tick();
    addr = 32'h8; #1;
    check("t2 hit 0x8", {31'd0, hit}, 32'd1);
    check("t2 q 0x4", q, 32'h12);
    tick();
    check("t2 q 0x8", q, 32'h13);
    check("t2 bus_req after", {31'd0, bus_req}, 32'd0);

    // 4: hold, clear, miss effects on q
    addr = 32'h4; hold = 1'b1;
    tick();
    check("t4 hold q", q, 32'h13);
    hold = 1'b0; clear = 1'b1;
    tick();
    check("t4 clear q", q, 32'h0);
    clear = 1'b0;
    tick();
    check("t4 hit q", q, 32'h12);

    // 3: conflicting tag on the same index, then refill of 0x0
    bus_log.delete();
    addr = 32'h800; #1;
    check("t3 miss 0x800", {31'd0, hit}, 32'd0);
    tick();
    check("t4 miss q", q, 32'h0);
    check("t3 bus_req", {31'd0, bus_req}, 32'd1);
    check("t3 bus_addr first", bus_addr, 32'h800);
    wait_hit(20, n);
    check("t3 remaining fill cycles", n, 32'd4);
    check_log("t3 bus_addr", 0, 32'h800);
    tick();
    check("t3 q 0x800", q, 32'hA5A5_0800);
    bus_log.delete();
    addr = 32'h0; #1;
    check("t3 0x0 evicted", {31'd0, hit}, 32'd0);
    wait_hit(20, n);
    check("t3 refill cycles", n, 32'd5);
    check_log("t3 refill", 0, 32'h0);
    tick();
    check("t3 q 0x0", q, 32'h11);

    // 5: reset in the middle of a fill
    addr = 32'h10;
    tick(); tick(); tick();
    check("t5 fill active", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    tick();
    check("t5 reset bus_req", {31'd0, bus_req}, 32'd0);
    check("t5 reset bus_addr", bus_addr, 32'h0);
    check("t5 reset q", q, 32'h0);
    reset = 1'b0; addr = 32'h0; #1;
    check("t5 0x0 miss after reset", {31'd0, hit}, 32'd0);

    // 5: redirect to 0x40 after word 1 of a slow fill of 0x0
    slave_delay = 2;
    bus_log.delete();
    n = 0;
    while (bus_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    check("t5 two words acked", bus_log.size(), 32'd2);
    addr = 32'h40; #1;
    check("t5 fill continues", bus_addr, 32'h8);
    wait_hit(200, n);
    check("t5 hit 0x40", {31'd0, hit}, 32'd1);
    check("t5 log size", bus_log.size(), 32'd8);
    check_log("t5 old line", 0, 32'h0);
    check_log("t5 new line", 4, 32'h40);
    addr = 32'h0; #1;
    check("t5 hit 0x0", {31'd0, hit}, 32'd1);
    tick();
    check("t5 q 0x0", q, 32'h11);
    addr = 32'h44;
    tick();
    check("t5 q 0x44", q, 32'hA5A5_0044);
    slave_delay = 0;

`ifdef ICACHE_INVALIDATE_EN
    // 6: invalidate all, then invalidate during fills
    addr = 32'h0; #1;
    check("t6 hit before inval", {31'd0, hit}, 32'd1);
    inval = 1'b1;
    tick();
    inval = 1'b0;
    check("t6 miss after inval", {31'd0, hit}, 32'd0);
    wait_hit(20, n);
    check("t6 refill cycles", n, 32'd5);
    addr = 32'h80; #1;
    check("t6 0x80 miss", {31'd0, hit}, 32'd0);
    tick();
    inval = 1'b1;
    tick();
    inval = 1'b0;
    n = 0;
    while (bus_req && n < 20) begin
      tick();
      n++;
    end
    check("t6 fill finished", {31'd0, bus_req}, 32'd0);
    check("t6 mid-fill inval miss", {31'd0, hit}, 32'd0);
    tick(); tick(); tick(); tick();
    inval = 1'b1;
    tick();
    inval = 1'b0;
    check("t6 same-cycle fill done", {31'd0, bus_req}, 32'd0);
    check("t6 same-cycle inval miss", {31'd0, hit}, 32'd0);
    wait_hit(20, n);
    check("t6 final refill cycles", n, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
